// File: rtl/keyboard_event_queue.sv
// keyboard_event_queue: PS/2 scancode parser with a typematic filter feeding an event FIFO.
// Defining KBD_EXT_KEYS_EN adds decoding of the E0-prefixed arrow keys.
`timescale 1ns/1ps
module keyboard_event_queue #(
    parameter int DEPTH  = 8,
    parameter int CODE_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               received_data,
    input  logic                     received_data_en,
    input  logic                     key_ready,
    output logic                     key_valid,
    output logic [CODE_W-1:0]        key_code,
    output logic                     key_release,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    function automatic logic [6:0] plain_map(input logic [7:0] b);
        case (b)
            8'h1C: return {1'b1, 6'd1};
            8'h32: return {1'b1, 6'd2};
            8'h21: return {1'b1, 6'd3};
            8'h23: return {1'b1, 6'd4};
            8'h24: return {1'b1, 6'd5};
            8'h2B: return {1'b1, 6'd6};
            8'h34: return {1'b1, 6'd7};
            8'h33: return {1'b1, 6'd8};
            8'h43: return {1'b1, 6'd9};
            8'h3B: return {1'b1, 6'd10};
            8'h42: return {1'b1, 6'd11};
            8'h4B: return {1'b1, 6'd12};
            8'h3A: return {1'b1, 6'd13};
            8'h31: return {1'b1, 6'd14};
            8'h44: return {1'b1, 6'd15};
            8'h4D: return {1'b1, 6'd16};
            8'h15: return {1'b1, 6'd17};
            8'h2D: return {1'b1, 6'd18};
            8'h1B: return {1'b1, 6'd19};
            8'h2C: return {1'b1, 6'd20};
            8'h3C: return {1'b1, 6'd21};
            8'h2A: return {1'b1, 6'd22};
            8'h1D: return {1'b1, 6'd23};
            8'h22: return {1'b1, 6'd24};
            8'h35: return {1'b1, 6'd25};
            8'h1A: return {1'b1, 6'd26};
            8'h29: return {1'b1, 6'd0};
            8'h5A: return {1'b1, 6'd30};
            8'h66: return {1'b1, 6'd31};
            default: return 7'd0;
        endcase
    endfunction

    function automatic logic [6:0] ext_map(input logic [7:0] b);
`ifdef KBD_EXT_KEYS_EN
        case (b)
            8'h75: return {1'b1, 6'd32};
            8'h72: return {1'b1, 6'd33};
            8'h6B: return {1'b1, 6'd34};
            8'h74: return {1'b1, 6'd35};
            default: return 7'd0;
        endcase
`else
        return plain_map(b);
`endif
    endfunction

    state_t              state;
    logic [5:0]          held;
    logic                held_valid;
    logic                ev_valid;
    logic [CODE_W-1:0]   ev_code;
    logic                ev_rel;
    logic                is_rel;
    logic                is_ext;
    logic                prefix;
    logic [6:0]          m;
    logic                dec;
    logic                sup;

    always_comb begin
        is_rel = state == BRK || state == EXT_BRK;
        is_ext = state == EXT || state == EXT_BRK;
        prefix = (state == IDLE && (received_data == 8'hF0 || received_data == 8'hE0)) ||
                 (state == EXT && received_data == 8'hF0);
        m      = is_ext ? ext_map(received_data) : plain_map(received_data);
        dec    = received_data_en && !prefix && m[6];
        sup    = !is_rel && held_valid && held == m[5:0];
    end

    // Decoded events are registered once before the FIFO, giving the two-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            held       <= '0;
            held_valid <= 1'b0;
            ev_valid   <= 1'b0;
            ev_code    <= '0;
            ev_rel     <= 1'b0;
        end else begin
            ev_valid <= dec && !sup;
            ev_code  <= CODE_W'(m[5:0]);
            ev_rel   <= is_rel;
            if (received_data_en)
                state <= (state == IDLE && received_data == 8'hF0) ? BRK :
                         (state == IDLE && received_data == 8'hE0) ? EXT :
                         (state == EXT  && received_data == 8'hF0) ? EXT_BRK : IDLE;
            if (dec && !is_rel) begin
                held       <= m[5:0];
                held_valid <= 1'b1;
            end else if (dec && held_valid && held == m[5:0]) begin
                held_valid <= 1'b0;
            end
        end
    end

    logic [CODE_W:0] mem [DEPTH];
    logic [AW-1:0]   wr;
    logic [AW-1:0]   rd;
    logic            pop;
    logic            do_push;

    assign key_valid   = fifo_count != '0;
    assign pop         = key_valid && key_ready;
    assign do_push     = ev_valid && (fifo_count != FULL || pop);
    assign key_code    = key_valid ? mem[rd][CODE_W-1:0] : '0;
    assign key_release = key_valid && mem[rd][CODE_W];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr] <= {ev_rel, ev_code};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr         <= '0;
            rd         <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            wr         <= wr + AW'(do_push);
            rd         <= rd + AW'(pop);
            fifo_count <= fifo_count + (AW+1)'(do_push) - (AW+1)'(pop);
            overflow   <= overflow || (ev_valid && !do_push);
        end
    end
endmodule

// File: tb/tb_keyboard_event_queue.sv
// tb_keyboard_event_queue: directed vector table plus multi-cycle sequences for the event queue.
`timescale 1ns/1ps
module tb_keyboard_event_queue;
    localparam int DEPTH  = 8;
    localparam int CODE_W = 6;
`ifdef KBD_EXT_KEYS_EN
    localparam bit EXTK = 1'b1;
`else
    localparam bit EXTK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        data = 8'h00;
    logic              en = 1'b0;
    logic              key_ready = 1'b0;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_release;
    logic [3:0]        fifo_count;
    logic              overflow;

    always #5 clk = ~clk;

    keyboard_event_queue #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
        .clk(clk), .rst(rst), .received_data(data), .received_data_en(en),
        .key_ready(key_ready), .key_valid(key_valid), .key_code(key_code),
        .key_release(key_release), .fifo_count(fifo_count), .overflow(overflow)
    );

    typedef struct {
        logic [7:0] b;
        logic       ev;
        logic       rel;
        logic [5:0] code;
    } vec_t;

    vec_t       tbl[$];
    logic [6:0] rec[$];
    int         vcyc = 0;
    int         errors = 0;
    int         checks = 0;

    always @(negedge clk) begin
        if (key_valid) vcyc++;
        if (key_valid && key_ready) rec.push_back({key_release, key_code});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 data = b;
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        key_ready = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    function automatic void add(input logic [7:0] b, input logic ev, input logic rel, input logic [5:0] code);
        tbl.push_back('{b, ev, rel, code});
    endfunction

    function automatic logic [6:0] rec_at(input int i);
        return (i < rec.size()) ? rec[i] : 7'h7F;
    endfunction

    logic [7:0] seq [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};

    initial begin
        add(8'h1C, 1, 0, 1);
        add(8'h1C, 0, 0, 0);
        add(8'hF0, 0, 0, 0);
        add(8'h1C, 1, 1, 1);
        add(8'h1C, 1, 0, 1);
        add(8'h32, 1, 0, 2);
        add(8'hF0, 0, 0, 0);
        add(8'h1C, 1, 1, 1);
        add(8'h29, 1, 0, 0);
        add(8'h5A, 1, 0, 30);
        add(8'h66, 1, 0, 31);
        add(8'h1A, 1, 0, 26);
        add(8'h15, 1, 0, 17);
        add(8'h77, 0, 0, 0);
        add(8'hF0, 0, 0, 0);
        add(8'h77, 0, 0, 0);
        add(8'h44, 1, 0, 15);
        add(8'hE0, 0, 0, 0);
        add(8'h75, EXTK, 0, 32);
        add(8'hE0, 0, 0, 0);
        add(8'hF0, 0, 0, 0);
        add(8'h75, EXTK, 1, 32);
        add(8'hE0, 0, 0, 0);
        add(8'h1C, !EXTK, 0, 1);
        add(8'hE0, 0, 0, 0);
        add(8'hF0, 0, 0, 0);
        add(8'h1C, !EXTK, 1, 1);

        do_reset();
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_release", key_release, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);

        foreach (tbl[i]) begin
            send(tbl[i].b);
            step(2);
            check($sformatf("row%0d_valid", i), key_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                check($sformatf("row%0d_code", i), key_code, tbl[i].code);
                check($sformatf("row%0d_release", i), key_release, tbl[i].rel);
            end
            key_ready = 1'b1;
            step(1);
            key_ready = 1'b0;
            check($sformatf("row%0d_count", i), fifo_count, 0);
        end

        // Latency and single-cycle pulses with the consumer always ready.
        do_reset();
        rec.delete();
        vcyc = 0;
        key_ready = 1'b1;
        send(8'h1C);
        check("lat_n1_valid", key_valid, 0);
        step(1);
        check("lat_n2_valid", key_valid, 1);
        send(8'hF0);
        send(8'h1C);
        step(5);
        key_ready = 1'b0;
        check("pulse_events", rec.size(), 2);
        check("pulse_ev0", rec_at(0), {1'b0, 6'd1});
        check("pulse_ev1", rec_at(1), {1'b1, 6'd1});
        check("pulse_cycles", vcyc, 2);

        // Repeated make codes collapse to one press.
        do_reset();
        rec.delete();
        key_ready = 1'b1;
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        step(5);
        key_ready = 1'b0;
        check("typematic_events", rec.size(), 2);
        check("typematic_ev0", rec_at(0), {1'b0, 6'd1});
        check("typematic_ev1", rec_at(1), {1'b1, 6'd1});

        // Overflow: DEPTH+2 presses with no consumer.
        do_reset();
        rec.delete();
        for (int i = 0; i < DEPTH + 2; i++) send(seq[i]);
        step(3);
        check("ovf_count", fifo_count, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_head", key_code, 1);
        step(3);
        check("ovf_head_stable", key_code, 1);
        check("ovf_head_release", key_release, 0);
        key_ready = 1'b1;
        step(12);
        key_ready = 1'b0;
        check("ovf_drained", rec.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("ovf_order%0d", i), rec_at(i), {1'b0, 6'(i + 1)});
        check("ovf_sticky", overflow, 1);
        check("ovf_empty", fifo_count, 0);

        // Full queue with simultaneous push and pop.
        do_reset();
        rec.delete();
        for (int i = 0; i < DEPTH; i++) send(seq[i]);
        step(3);
        check("full_count", fifo_count, DEPTH);
        check("full_overflow", overflow, 0);
        send(8'h43);
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
        check("pushpop_count", fifo_count, DEPTH);
        check("pushpop_overflow", overflow, 0);
        key_ready = 1'b1;
        step(12);
        key_ready = 1'b0;
        check("pushpop_drained", rec.size(), DEPTH + 1);
        for (int i = 0; i <= DEPTH; i++)
            check($sformatf("pushpop_order%0d", i), rec_at(i), {1'b0, 6'(i + 1)});

        // Reset in the middle of a break sequence.
        do_reset();
        send(8'hF0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        send(8'h1C);
        step(2);
        check("midrst_valid", key_valid, 1);
        check("midrst_code", key_code, 1);
        check("midrst_release", key_release, 0);

        // Strobes coincident with reset are ignored.
        do_reset();
        rst = 1'b1;
        data = 8'h1C;
        en = 1'b1;
        step(1);
        en = 1'b0;
        rst = 1'b0;
        step(3);
        check("rststrobe_valid", key_valid, 0);
        rst = 1'b1;
        data = 8'hF0;
        en = 1'b1;
        step(1);
        en = 1'b0;
        rst = 1'b0;
        send(8'h1C);
        step(2);
        check("rststrobe_press", key_valid, 1);
        check("rststrobe_release", key_release, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
